// File: rtl/mdu_divider.sv
// ============================================================================
// Module   : mdu_divider
// Purpose  : Iterative restoring radix-2 divider for MIPS DIV/DIVU.
//            Works on operand magnitudes, one quotient bit per clock, then
//            applies the sign fix-up in a final cycle. Quotient -> LO,
//            remainder -> HI.
// Ports    : clk, rst (sync, active-high)
//            start, is_signed, cancel, dividend, divisor   (inputs)
//            busy, done, quotient, remainder, div_zero     (outputs)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  cancel,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] part_rem;   // partial remainder
  logic [DATA_WIDTH-1:0] quo_sh;     // dividend shifts out, quotient shifts in
  logic [DATA_WIDTH-1:0] div_mag;    // divisor magnitude
  logic [DATA_WIDTH-1:0] dvd_orig;   // raw dividend, returned as remainder on /0
  logic [CNT_W-1:0]      cnt;
  logic                  q_neg;
  logic                  r_neg;
  logic                  dz;

  // Operand magnitudes. Negating 0x8000_0000 yields 0x8000_0000, which is
  // the correct unsigned magnitude as long as nothing sign-extends it.
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed & dividend[DATA_WIDTH-1];
  assign b_neg = is_signed & divisor[DATA_WIDTH-1];
  assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;

  // One restoring step: shift next dividend bit into the partial remainder
  // and trial-subtract. The extra top bit holds the borrow.
  logic [DATA_WIDTH:0] shifted, diff;

  assign shifted = {part_rem, quo_sh[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, div_mag};

  assign busy = (state != IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        if (cancel)                 state_nxt = IDLE;
        else if (cnt == LAST_ITER)  state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      part_rem  <= '0;
      quo_sh    <= '0;
      div_mag   <= '0;
      dvd_orig  <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            part_rem <= '0;
            quo_sh   <= a_mag;
            div_mag  <= b_mag;
            dvd_orig <= dividend;
            cnt      <= '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            dz       <= (divisor == '0);
          end
        end
        CALC: begin
          if (!cancel) begin
            if (!diff[DATA_WIDTH]) begin
              part_rem <= diff[DATA_WIDTH-1:0];
              quo_sh   <= {quo_sh[DATA_WIDTH-2:0], 1'b1};
            end else begin
              // Shifted value is below the divisor, so it fits in DATA_WIDTH.
              part_rem <= shifted[DATA_WIDTH-1:0];
              quo_sh   <= {quo_sh[DATA_WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          // A flush in the final cycle leaves the previous results untouched.
          if (!cancel) begin
            if (dz) begin
              quotient  <= '1;
              remainder <= dvd_orig;
            end else begin
              quotient  <= q_neg ? (~quo_sh + 1'b1) : quo_sh;
              remainder <= r_neg ? (~part_rem + 1'b1) : part_rem;
            end
            div_zero <= dz;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_divider.sv
// ============================================================================
// Module   : tb_mdu_divider
// Purpose  : Self-checking bench for mdu_divider: table of directed divides
//            plus hand-written sequences for ignored start, cancel, reset
//            mid-operation and back-to-back starts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_divider #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive a request on the current (falling) edge.
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
  endtask

  // Drop start after one cycle, then wait (bounded) for done. lat counts
  // falling edges from the start edge; bcnt counts cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input int idx);
    int lat, bcnt;
    string nm;
    nm = $sformatf("v%0d", idx);
    do_start(vecs[idx].sgn, vecs[idx].a, vecs[idx].b);
    wait_done(lat, bcnt);
    chk({nm, "_latency"}, 32'(lat), 32'd34);
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd33);
    chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({nm, "_quotient"}, quotient, vecs[idx].q);
    chk({nm, "_remainder"}, remainder, vecs[idx].r);
    chk({nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, vecs[idx].dz});
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_q_held"}, quotient, vecs[idx].q);
    chk({nm, "_r_held"}, remainder, vecs[idx].r);
  endtask

  initial begin
    int lat, bcnt, ndone;

    //            sgn   a             b             q             r             dz
    vecs[0] = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 32'd1,        1'b0};
    vecs[3] = '{1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[4] = '{1'b1, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[5] = '{1'b0, 32'd5,        32'd3,        32'd1,        32'd2,        1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0};
    vecs[7] = '{1'b1, 32'h8000_0000, 32'd2,        32'hC000_0000, 32'd0,        1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[9] = '{1'b1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,        1'b0};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // start while busy is ignored: 1000/3 completes undisturbed.
    do_start(1'b0, 32'd1000, 32'd3);
    @(negedge clk);                           // N1
    start = 1'b0;
    repeat (4) @(negedge clk);                // N5
    do_start(1'b0, 32'd1, 32'd1);
    wait_done(lat, bcnt);
    chk("ign_latency", 32'(lat + 5), 32'd34);
    chk("ign_q", quotient, 32'd333);
    chk("ign_r", remainder, 32'd1);
    @(negedge clk);

    // cancel at cycle 10: no done, old results kept, then 9/4 straight away.
    do_start(1'b0, 32'd1000, 32'd7);
    @(negedge clk);                           // N1
    start = 1'b0;
    repeat (4) @(negedge clk);                // N5
    do_start(1'b1, 32'd50, 32'd5);
    @(negedge clk);                           // N6
    start = 1'b0;
    repeat (4) @(negedge clk);                // N10
    cancel = 1'b1;
    @(negedge clk);                           // N11
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_done", {31'd0, done}, 32'd0);
    chk("cancel_q_kept", quotient, 32'd333);
    chk("cancel_r_kept", remainder, 32'd1);
    do_start(1'b0, 32'd9, 32'd4);
    wait_done(lat, bcnt);
    chk("after_cancel_latency", 32'(lat), 32'd34);
    chk("after_cancel_q", quotient, 32'd2);
    chk("after_cancel_r", remainder, 32'd1);
    @(negedge clk);

    // Reset at cycle 20 of an operation.
    do_start(1'b0, 32'd50, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);               // N20
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);

    // Back-to-back: each new start is raised in the previous done cycle.
    do_start(1'b0, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b0_q", quotient, 32'd14);
    do_start(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bcnt);
    chk("b2b1_latency", 32'(lat), 32'd34);
    chk("b2b1_q", quotient, 32'hFFFF_FFFD);
    chk("b2b1_r", remainder, 32'hFFFF_FFFF);
    do_start(1'b0, 32'd9, 32'd4);
    wait_done(lat, bcnt);
    chk("b2b2_latency", 32'(lat), 32'd34);
    chk("b2b2_q", quotient, 32'd2);
    chk("b2b2_r", remainder, 32'd1);
    @(negedge clk);
    chk("b2b2_done_pulse", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Iterative 32-bit integer divider for MIPS DIV/DIVU, producing the quotient (LO) and remainder (HI).
- Sits beside the combinational ALU in the execute stage. The pipeline stalls while `busy` is high.
- Uses a restoring radix-2 algorithm on operand magnitudes, one quotient bit per cycle, with a start/busy/done handshake.
- Sign fix-up is applied in a final cycle.

Parameters:
- DATA_WIDTH, 32, operand and result width. The iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only when busy=0.
- is_signed  in  1  1=DIV (two's complement), 0=DIVU; sampled with start.
- cancel  in  1  pipeline flush/exception; aborts an operation in progress.
- dividend  in  DATA_WIDTH  A operand; sampled with start.
- divisor  in  DATA_WIDTH  B operand; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse; quotient/remainder/div_zero are valid from this cycle.
- quotient  out  DATA_WIDTH  LO result; holds its value until the next completion.
- remainder  out  DATA_WIDTH  HI result; holds its value until the next completion.
- div_zero  out  1  divisor was zero for the completed operation; held with the results.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; internal counter and shift registers are cleared. rst has priority over every other input.
- States: IDLE, CALC, FIX.
- IDLE:
  - If start=1 at an edge, latch operands and flags: |dividend| and |divisor| (magnitudes only when is_signed=1), q_neg = sign(A) XOR sign(B), r_neg = sign(A), dz = (divisor==0).
  - Clear partial remainder; counter=0; go to CALC.
  - start=0 stays in IDLE. cancel in IDLE has no effect.
- CALC, each edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude using a (DATA_WIDTH+1)-bit subtract.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - counter increments. After the DATA_WIDTH-th iteration, go to FIX.
- FIX, one edge:
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -R : R.
  - div_zero = dz; done=1 for exactly the following cycle; go to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E(DATA_WIDTH+1), i.e. 33 cycles after acceptance at the default width. busy is high between E0 and that edge and low in the done cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted (state is IDLE).
- start while busy=1: ignored. Operand inputs are not resampled.
- cancel=1 in CALC or FIX: next state IDLE, busy=0, no done pulse, and previous result registers are unchanged. rst takes precedence over cancel.
- Divide by zero:
  - Same latency.
  - quotient = all ones, remainder = the original dividend (not its magnitude), div_zero=1, regardless of is_signed.
  - Sign fix-up is bypassed.
- Signed overflow (0x8000_0000 / 0xFFFF_FFFF, is_signed=1): quotient=0x8000_0000, remainder=0 (natural two's-complement wrap). div_zero=0; no separate overflow flag.
- Magnitude of 0x8000_0000 is represented as unsigned 0x8000_0000; the datapath must not sign-extend it.
- Remainder sign always equals dividend sign (or zero). |remainder| < |divisor|. dividend = quotient*divisor + remainder, modulo 2^DATA_WIDTH.
- Outputs change only at clock edges. No combinational path from inputs to outputs.

Test Plan:
- Reset then unsigned 100/7 (is_signed=0): busy=1 for 33 cycles; done pulse once; quotient=14, remainder=2, div_zero=0. Results held after done drops.
- Signed 0xFFFF_FFF9 (-7) / 2: quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1). Repeat with DIVU on the same operands: quotient=0x7FFF_FFFC, remainder=1.
- Divide by zero, 0x1234_5678/0 (both signedness values): same latency; quotient=0xFFFF_FFFF, remainder=0x1234_5678, div_zero=1. A following valid divide clears div_zero.
- Signed 0x8000_0000/0xFFFF_FFFF → quotient=0x8000_0000, remainder=0. Signed 0x8000_0000/2 → quotient=0xC000_0000, remainder=0.
- Start 1000/3, raise start with new operands at cycle 5 (ignored), pulse cancel at cycle 10: busy drops the next cycle, no done, and the old results remain. A new start (9/4) accepted immediately completes with quotient=2, remainder=1.
- Assert rst at cycle 20 of an operation: all outputs return to 0 the next cycle, and no done is produced. Back-to-back starts in done cycles complete every 34 cycles.
